bht_update_ctrl: RTL and testbench
==================================

Name: bht_update_ctrl

Overview:
- Sequencer for the 2-bit Branch History Table.
- Owns the BHT write port and read port-1.
- Clears the table after reset or flush by sweeping every entry; this is required because block- and LUT-RAM targets have no reset.
- Applies resolved-branch outcomes from execute as pipelined read-modify-write saturating-counter updates, one per cycle, with write-to-read forwarding. Fetch keeps exclusive use of read port-0.

Parameters:
- DPT, 64, BHT entries (power of 2); must match the BHT instance.
- RSTVAL, 2'b10, value written to every entry by the init sweep.
- ADW, $clog2(DPT), derived address width (localparam).

Ports:
- clk  in  1  clock
- srst  in  1  synchronous reset, active-high
- i_flush  in  1  restart the init sweep (BHT invalidate)
- i_upd_valid  in  1  resolved-branch update valid
- o_upd_ready  out  1  update accepted when valid & ready
- i_upd_idx  in  ADW  BHT index of the resolved branch
- i_upd_taken  in  1  branch outcome, 1 = taken
- o_init_busy  out  1  sweep in progress; fetch must ignore BHT predictions
- o_bht_wren  out  1  to BHT i_wren
- o_bht_waddr  out  ADW  to BHT i_waddr
- o_bht_wdata  out  2  to BHT i_wdata
- o_bht_rden1  out  1  to BHT i_rden1
- o_bht_raddr1  out  ADW  to BHT i_raddr1
- i_bht_rdata1  in  2  from BHT o_rdata1; valid 1 cycle after the read

Behaviour:
- Interface (already decided): one clock, clk; reset srst is synchronous and active-high. No other clock or reset.
- While srst=1, state is INIT with sweep address 0, and the outputs are:
  - o_bht_wren=0, o_bht_rden1=0, o_upd_ready=0, o_init_busy=1
  - S1 stage invalid, forward register invalid
  - waddr/raddr/wdata = 0
- FSM states: INIT and RUN.
- INIT:
  - Each cycle: o_bht_wren=1, o_bht_waddr=sweep counter, o_bht_wdata=RSTVAL; counter then increments.
  - First cycle after srst falls writes address 0. The cycle writing DPT-1 is the last INIT cycle.
  - Next cycle enters RUN: o_init_busy=0, o_upd_ready=1. Sweep length is exactly DPT cycles.
- RUN: o_upd_ready=1 (registered, state-based only). Accept occurs at cycle t when i_upd_valid=1.
  - Stage 0 (cycle t):
    - o_bht_rden1=1, o_bht_raddr1=i_upd_idx (combinational).
    - idx and taken are captured into S1 at the end of the cycle.
  - Stage 1 (cycle t+1):
    - cur = fwd_hit ? fwd_data : i_bht_rdata1.
    - Next value: taken gives min(cur+1, 3); not taken gives max(cur-1, 0). No 2-bit wrap (3+1 = 3, 0-1 = 0).
    - o_bht_wren=1, o_bht_waddr=S1.idx, o_bht_wdata=next, all combinational from S1.
  - Forwarding:
    - Forward register holds {valid, addr, data} of the BHT write made in the previous cycle, RUN writes only.
    - fwd_hit = valid & addr==S1.idx. This covers the BHT read-before-write hazard of back-to-back updates to the same index.
    - Writes two or more cycles old are visible in the RAM, so no deeper forwarding.
  - Throughput is 1 update per cycle. An idle S1 gives o_bht_wren=0; no accept gives o_bht_rden1=0.
- i_flush in RUN:
  - Next state INIT, sweep counter = 0.
  - An update accepted in the same cycle is dropped: no read-data use, no write.
  - An S1 update in the flush cycle still writes; this is harmless because the sweep overwrites it.
  - Forward register is cleared.
- i_flush in INIT: sweep restarts from address 0 in the next cycle.
- srst mid-sweep or mid-update: immediate return to reset state; all in-flight work is discarded.
- srst has priority over i_flush.
- RUN never stalls the requester; the only backpressure is o_upd_ready=0 during INIT.

Test Plan:
- Reset sweep, DPT=64, RSTVAL=2'b10: srst low at cycle 0 -> 64 writes (addr 0..63, data 2'b10), o_init_busy high cycles 0..63 and low at 64; o_upd_ready rises at cycle 64.
- Saturation: updates to idx 5 with taken=1,1,1 spaced 3 cycles apart -> writes 3, 3, 3. Then taken=0 ×4 -> writes 2, 1, 0, 0.
- Back-to-back same index: idx 9 (entry=2), taken=1 on consecutive cycles ×2 -> writes 3 then 3. Then not-taken ×3 consecutive -> writes 2, 1, 0 via forwarding, with no stale read.
- Alternating indices: 4,7,4,7 taken=1 back-to-back from entry 2 -> writes 3,3,3,3; the forward-hit path is never taken because the index differs from the previous write.
- Flush mid-stream: update accepted on the same cycle as i_flush -> no write for it. Next cycle is INIT at addr 0 and o_init_busy=1 for 64 cycles; afterwards idx 5 reads back 2'b10.
- srst asserted at sweep addr 30 -> o_bht_wren=0 while srst is high; after release the sweep restarts at addr 0 and still takes the full 64 cycles.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// rtl/bht_update_ctrl.sv - BHT init sweep and pipelined saturating-counter update sequencer
module bht_update_ctrl #(
    parameter int          DPT    = 64,
    parameter logic [1:0]  RSTVAL = 2'b10,
    localparam int         ADW    = $clog2(DPT)
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           i_flush,
    input  logic           i_upd_valid,
    output logic           o_upd_ready,
    input  logic [ADW-1:0] i_upd_idx,
    input  logic           i_upd_taken,
    output logic           o_init_busy,
    output logic           o_bht_wren,
    output logic [ADW-1:0] o_bht_waddr,
    output logic [1:0]     o_bht_wdata,
    output logic           o_bht_rden1,
    output logic [ADW-1:0] o_bht_raddr1,
    input  logic [1:0]     i_bht_rdata1
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADW-1:0] LAST_ADDR = ADW'(DPT - 1);

    state_t         state_q;
    logic [ADW-1:0] sweep_q;
    logic           ready_q;
    logic           busy_q;

    logic           s1_valid;
    logic [ADW-1:0] s1_idx;
    logic           s1_taken;

    logic           fwd_valid;
    logic [ADW-1:0] fwd_addr;
    logic [1:0]     fwd_data;

    logic           accept;
    logic           fwd_hit;
    logic [1:0]     cur;
    logic [1:0]     nxt;

    // srst gates the strobes combinationally so nothing reaches the RAM in the cycle it is raised
    assign accept  = ~srst & ready_q & i_upd_valid;
    assign fwd_hit = fwd_valid & (fwd_addr == s1_idx);

    always_comb begin
        cur = fwd_hit ? fwd_data : i_bht_rdata1;
        if (s1_taken) begin
            nxt = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
        end else begin
            nxt = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
        end
    end

    always_comb begin
        o_bht_wren   = 1'b0;
        o_bht_waddr  = '0;
        o_bht_wdata  = 2'b00;
        o_bht_rden1  = 1'b0;
        o_bht_raddr1 = '0;
        if (!srst) begin
            if (state_q == INIT) begin
                o_bht_wren  = 1'b1;
                o_bht_waddr = sweep_q;
                o_bht_wdata = RSTVAL;
            end else if (s1_valid) begin
                o_bht_wren  = 1'b1;
                o_bht_waddr = s1_idx;
                o_bht_wdata = nxt;
            end
            if (accept) begin
                o_bht_rden1  = 1'b1;
                o_bht_raddr1 = i_upd_idx;
            end
        end
    end

    assign o_upd_ready = ready_q;
    assign o_init_busy = busy_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= INIT;
            sweep_q   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_taken  <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= 2'b00;
        end else begin
            case (state_q)
                INIT: begin
                    s1_valid  <= 1'b0;
                    fwd_valid <= 1'b0;
                    if (i_flush) begin
                        sweep_q <= '0;
                    end else if (sweep_q == LAST_ADDR) begin
                        state_q <= RUN;
                        sweep_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                RUN: begin
                    s1_valid  <= accept & ~i_flush;
                    s1_idx    <= i_upd_idx;
                    s1_taken  <= i_upd_taken;
                    // only the most recent write can be hidden from the RAM read port
                    fwd_valid <= s1_valid & ~i_flush;
                    fwd_addr  <= s1_idx;
                    fwd_data  <= nxt;
                    if (i_flush) begin
                        state_q <= INIT;
                        sweep_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= INIT;
                    sweep_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb/tb_bht_update_ctrl.sv - self-checking bench for bht_update_ctrl against a table-level model
module tb_bht_update_ctrl;

    localparam int         DPT    = 64;
    localparam logic [1:0] RSTVAL = 2'b10;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       flush = 1'b0;
    logic       upd_valid = 1'b0;
    logic [5:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic       init_busy;
    logic       bht_wren;
    logic [5:0] bht_waddr;
    logic [1:0] bht_wdata;
    logic       bht_rden1;
    logic [5:0] bht_raddr1;
    logic [1:0] bht_rdata1 = 2'b00;

    int errors = 0;
    int checks = 0;

    bht_update_ctrl #(.DPT(DPT), .RSTVAL(RSTVAL)) dut (
        .clk          (clk),
        .srst         (srst),
        .i_flush      (flush),
        .i_upd_valid  (upd_valid),
        .o_upd_ready  (upd_ready),
        .i_upd_idx    (upd_idx),
        .i_upd_taken  (upd_taken),
        .o_init_busy  (init_busy),
        .o_bht_wren   (bht_wren),
        .o_bht_waddr  (bht_waddr),
        .o_bht_wdata  (bht_wdata),
        .o_bht_rden1  (bht_rden1),
        .o_bht_raddr1 (bht_raddr1),
        .i_bht_rdata1 (bht_rdata1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // BHT RAM emulation: read-before-write, one-cycle read latency, no reset
    logic [1:0] ram [DPT];
    initial for (int i = 0; i < DPT; i++) ram[i] = 2'($urandom);
    always @(posedge clk) begin
        if (bht_wren) ram[bht_waddr] <= bht_wdata;
        if (bht_rden1) bht_rdata1 <= ram[bht_raddr1];
    end

    // Reference: the counter table as the specification defines it, plus the sweep position
    logic [1:0] ref_tab [DPT];
    bit         m_known = 0;
    bit         m_init = 1;
    int         m_sweep = 0;
    bit         p_valid = 0;
    int         p_idx = 0;
    int         p_data = 0;
    bit         e_wren, e_rden;
    int         nv;
    int         wlog [$];
    int         exp_q [$];

    function automatic int sat(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            e_wren = !srst && (m_init || p_valid);
            e_rden = !srst && !m_init && upd_valid;
            chk("init_busy", int'(init_busy), int'(m_init));
            chk("upd_ready", int'(upd_ready), int'(!m_init));
            chk("bht_wren", int'(bht_wren), int'(e_wren));
            if (e_wren) begin
                chk("bht_waddr", int'(bht_waddr), m_init ? m_sweep : p_idx);
                chk("bht_wdata", int'(bht_wdata), m_init ? int'(RSTVAL) : p_data);
            end
            chk("bht_rden1", int'(bht_rden1), int'(e_rden));
            if (e_rden) chk("bht_raddr1", int'(bht_raddr1), int'(upd_idx));
        end
        if (bht_wren && !init_busy && !srst) wlog.push_back(int'(bht_waddr) * 4 + int'(bht_wdata));

        if (srst) begin
            m_known = 1; m_init = 1; m_sweep = 0; p_valid = 0;
            for (int i = 0; i < DPT; i++) ref_tab[i] = RSTVAL;
        end else if (m_init) begin
            p_valid = 0;
            if (flush) m_sweep = 0;
            else if (m_sweep == DPT - 1) begin m_init = 0; m_sweep = 0; end
            else m_sweep++;
        end else begin
            p_valid = 0;
            if (upd_valid && !flush) begin
                nv = sat(int'(ref_tab[upd_idx]), upd_taken);
                ref_tab[upd_idx] = 2'(nv);
                p_valid = 1; p_idx = int'(upd_idx); p_data = nv;
            end
            if (flush) begin
                m_init = 1; m_sweep = 0;
                for (int i = 0; i < DPT; i++) ref_tab[i] = RSTVAL;
            end
        end
    end

    task automatic cyc(input bit r, input bit v, input int idx, input bit t, input bit f);
        srst = r; upd_valid = v; upd_idx = 6'(idx); upd_taken = t; flush = f;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        int first = -1;
        srst = 0; upd_valid = 0; flush = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!init_busy) break;
            if (n == 0) first = int'(bht_waddr);
            n++;
        end
        chk({name, "_len"}, n, DPT);
        chk({name, "_first_addr"}, first, 0);
        @(posedge clk); #1;
    endtask

    task automatic expect_log(input string name);
        chk({name, "_count"}, wlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) chk(name, wlog[i], exp_q[i]);
        wlog.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_busy", int'(init_busy), 1);
        chk("reset_ready", int'(upd_ready), 0);
        chk("reset_wren", int'(bht_wren), 0);
        @(posedge clk); #1;
        count_sweep("reset_sweep");
        wlog.delete();

        // saturation with spaced updates
        for (int i = 0; i < 3; i++) begin cyc(0, 1, 5, 1, 0); idle(2); end
        for (int i = 0; i < 4; i++) begin cyc(0, 1, 5, 0, 0); idle(2); end
        exp_q = '{23, 23, 23, 22, 21, 20, 20};
        expect_log("saturate_idx5");

        // back-to-back same index relies on forwarding
        cyc(0, 1, 9, 1, 0); cyc(0, 1, 9, 1, 0);
        cyc(0, 1, 9, 0, 0); cyc(0, 1, 9, 0, 0); cyc(0, 1, 9, 0, 0);
        idle(2);
        exp_q = '{39, 39, 38, 37, 36};
        expect_log("b2b_idx9");

        // alternating indices
        cyc(0, 1, 4, 1, 0); cyc(0, 1, 7, 1, 0); cyc(0, 1, 4, 1, 0); cyc(0, 1, 7, 1, 0);
        idle(2);
        exp_q = '{19, 31, 19, 31};
        expect_log("alt_4_7");

        // flush with an update accepted in the same cycle
        cyc(0, 1, 12, 1, 0);
        cyc(0, 1, 20, 1, 1);
        count_sweep("flush_sweep");
        exp_q = '{51};
        expect_log("flush_drop");
        chk("flush_ram5", int'(ram[5]), 2);
        cyc(0, 1, 5, 1, 0); idle(2);
        exp_q = '{23};
        expect_log("post_flush_idx5");

        // srst in the middle of a sweep
        cyc(0, 0, 0, 0, 1);
        srst = 0; upd_valid = 0; flush = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (init_busy && bht_waddr == 6'd29) break;
        end
        @(posedge clk); #1;
        srst = 1;
        @(negedge clk);
        chk("srst_at30_wren", int'(bht_wren), 0);
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0);
        count_sweep("srst_resweep");
        wlog.delete();

        // randomized traffic, narrow index range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 799) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, DPT - 1) : $urandom_range(0, 3),
                $urandom_range(0, 1), ($urandom_range(0, 299) == 0));
        end
        wlog.delete();

        srst = 0; upd_valid = 0; flush = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (upd_ready && !init_busy) break;
        end
        chk("final_ready", int'(upd_ready), 1);
        @(posedge clk); #1;
        idle(3);
        for (int i = 0; i < DPT; i++) chk("final_ram", int'(ram[i]), int'(ref_tab[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
